key_event_gen: RTL
==================

// Module: key_event_gen
// PURPOSE
//  Front-end for the clock's push buttons (mode, position, increment, alarm).
//  Synchronises the raw active-low switches into clk, debounces each key with its own counter, and emits events.
//  Events are single-cycle press/release/long-press/auto-repeat pulses plus a debounced level.
//  Sits between the board pins and the clock controller.
//  The controller consumes the pulses as clk-domain enables instead of using the switches as clocks.
// PARAMETERS
//  NUM_KEY   4           number of independent keys
//  CNT_W     26          width of per-key cycle counter
//  DEB_CYC   1_000_000   consecutive stable samples to accept a change (20 ms @ 50 MHz)
//  LONG_CYC  50_000_000  cycles held after o_press before o_long (1 s)
//  REP_CYC   10_000_000  auto-repeat period after o_long (200 ms)
//  Constraints: DEB_CYC, LONG_CYC and REP_CYC are each >= 1 and < 2**CNT_W.
// PORTS
//  clk        in   1        system clock, 50 MHz
//  rst_n      in   1        reset; asynchronous assert, active-low
//  i_sw       in   NUM_KEY  raw switches, active-low (0 = pressed), asynchronous to clk
//  o_level    out  NUM_KEY  debounced level, 1 = pressed
//  o_press    out  NUM_KEY  1-cycle pulse on accepted press
//  o_release  out  NUM_KEY  1-cycle pulse on accepted release
//  o_long     out  NUM_KEY  1-cycle pulse when held LONG_CYC cycles past o_press
//  o_rep      out  NUM_KEY  1-cycle auto-repeat pulse while held beyond o_long
// BEHAVIOUR
//  Reset:
//  - Synchroniser flops reset to 1 (released). Every key enters IDLE. All counters and outputs reset to 0.
//  - Reset asserted mid-operation aborts the key at once; no pulse is emitted.
//  - A key still held after reset is treated as a new press and emits o_press after normal latency.
//  Synchronisation and keys:
//  - Each key uses a 2-flop synchroniser; s = ~sync2 (1 = pressed).
//  - Keys are fully independent; simultaneous events on several keys all appear in the same cycle.
//  Per-key FSM (all outputs registered):
//  - IDLE: s=1 -> DEB_P with cnt=1.
//  - DEB_P: s=1 and cnt==DEB_CYC -> HELD, pulse o_press, cnt=0. s=1 otherwise: cnt++. s=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
//  - HELD: s=1 and cnt==LONG_CYC-1 -> LONG, pulse o_long, set lng=1, cnt=0. s=1 otherwise: cnt++. s=0 -> DEB_R, cnt=1.
//  - LONG: s=1 and cnt==REP_CYC-1 -> pulse o_rep, cnt=0. s=1 otherwise: cnt++. s=0 -> DEB_R, cnt=1.
//  - DEB_R: s=0 and cnt==DEB_CYC -> IDLE, pulse o_release, clear lng. s=0 otherwise: cnt++. s=1 -> back to LONG if lng else HELD, cnt=0 (no new o_press).
//  Outputs and timing:
//  - o_level=1 in HELD, LONG, DEB_R; otherwise 0.
//  - Press latency: with i_sw stable low from edge k, o_press is high in the cycle after edge k+DEB_CYC+2. Release latency is identical.
//  - Pulses on one key are mutually exclusive in any cycle; each is exactly 1 clk wide.
//  - Counters never wrap; they saturate by construction because comparisons precede the increment.
// CONFIGURATION
//  KEY_AUTO_REPEAT_EN defined:
//  - LONG state generates o_rep every REP_CYC cycles as above.
//  KEY_AUTO_REPEAT_EN undefined:
//  - o_rep is tied to 0 and the repeat counter logic is removed.
//  - LONG holds with cnt frozen at 0; o_long still fires once per hold.
// TESTING (bench params: NUM_KEY=4, CNT_W=8, DEB_CYC=4, LONG_CYC=20, REP_CYC=5)
//  1. Reset then i_sw=4'b1111 for 100 cycles -> all outputs stay 0.
//  2. i_sw[0] low from edge 10, held 12 cycles, then high ->
//     o_press[0] high after edge 16 only; o_level[0] 1 from there until o_release[0] pulse after edge 28; no o_long.
//  3. i_sw[1] toggles low/high every 2 cycles for 40 cycles -> no pulses and o_level[1]=0 throughout.
//  4. i_sw[2] held low for 60 cycles (repeat macro on) ->
//     o_press, then o_long 20 cycles later, then o_rep every 5 cycles, then a single o_release after letting go.
//     Same stimulus with the macro off -> o_rep stays 0.
//  5. Keys 0 and 3 pressed on the same edge -> o_press=4'b1001 in one cycle.
//     A 2-cycle high glitch during the hold -> no o_release and no second o_press.
//  6. rst_n pulsed low while key 2 is in LONG -> outputs 0 at once; o_press[2] re-fires DEB_CYC+2 cycles after reset release.

Source files
------------

// File: rtl/key_event_gen.sv
// ============================================================================
// Module      : key_event_gen
// Description : Push-button front end for the clock. Synchronises the raw
//               active-low switches into clk and debounces each key with its
//               own counter. Emits a debounced level plus single-cycle
//               press / release / long-press / auto-repeat pulses that the
//               clock controller uses as clk-domain enables.
// Config      : define KEY_AUTO_REPEAT_EN to enable o_rep generation in the
//               LONG state; when undefined o_rep is tied low and the repeat
//               counter logic is removed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_event_gen #(
  parameter int NUM_KEY  = 4,
  parameter int CNT_W    = 26,
  parameter int DEB_CYC  = 1_000_000,
  parameter int LONG_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_KEY-1:0] i_sw,
  output logic [NUM_KEY-1:0] o_level,
  output logic [NUM_KEY-1:0] o_press,
  output logic [NUM_KEY-1:0] o_release,
  output logic [NUM_KEY-1:0] o_long,
  output logic [NUM_KEY-1:0] o_rep
);

  // Per-key FSM encoding
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_DEB_P = 3'd1;
  localparam logic [2:0] c_ST_HELD  = 3'd2;
  localparam logic [2:0] c_ST_LONG  = 3'd3;
  localparam logic [2:0] c_ST_DEB_R = 3'd4;

  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_DEB     = CNT_W'(DEB_CYC);
  localparam logic [CNT_W-1:0] c_LONG_M1 = CNT_W'(LONG_CYC - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_REP_M1  = CNT_W'(REP_CYC - 1);
`endif

  // Every timing constant must be non-zero and fit the counter, otherwise the
  // terminal comparisons can never match.
  generate
    if (DEB_CYC < 1 || LONG_CYC < 1 || REP_CYC < 1 ||
        longint'(DEB_CYC)  >= (longint'(1) << CNT_W) ||
        longint'(LONG_CYC) >= (longint'(1) << CNT_W) ||
        longint'(REP_CYC)  >= (longint'(1) << CNT_W)) begin : g_param_err
      $error("key_event_gen: timing parameter out of range for CNT_W");
    end
  endgenerate

  logic [NUM_KEY-1:0] sync1_q;
  logic [NUM_KEY-1:0] sync2_q;
  logic [NUM_KEY-1:0] w_s;

  // Two-flop synchroniser; resets to all-released so a reset never looks like a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
    end
  end

  assign w_s = ~sync2_q;  // 1 = pressed

  generate
    for (genvar k = 0; k < NUM_KEY; k++) begin : g_key
      logic [2:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             lng_q, lng_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic             long_q, long_d;
`ifdef KEY_AUTO_REPEAT_EN
      logic             rep_q, rep_d;
`endif

      // Next-state, counter and pulse decode for one key
      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lng_d     = lng_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        rep_d     = 1'b0;
`endif
        case (state_q)
          c_ST_IDLE: begin
            if (w_s[k]) begin
              state_d = c_ST_DEB_P;
              cnt_d   = c_ONE;
            end
          end
          c_ST_DEB_P: begin
            if (w_s[k]) begin
              if (cnt_q == c_DEB) begin
                state_d = c_ST_HELD;
                press_d = 1'b1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + c_ONE;
              end
            end else begin
              // bounce: drop back silently
              state_d = c_ST_IDLE;
              cnt_d   = '0;
            end
          end
          c_ST_HELD: begin
            if (w_s[k]) begin
              if (cnt_q == c_LONG_M1) begin
                state_d = c_ST_LONG;
                long_d  = 1'b1;
                lng_d   = 1'b1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + c_ONE;
              end
            end else begin
              state_d = c_ST_DEB_R;
              cnt_d   = c_ONE;
            end
          end
          c_ST_LONG: begin
            if (w_s[k]) begin
`ifdef KEY_AUTO_REPEAT_EN
              if (cnt_q == c_REP_M1) begin
                rep_d = 1'b1;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q + c_ONE;
              end
`else
              cnt_d = '0;
`endif
            end else begin
              state_d = c_ST_DEB_R;
              cnt_d   = c_ONE;
            end
          end
          c_ST_DEB_R: begin
            if (!w_s[k]) begin
              if (cnt_q == c_DEB) begin
                state_d   = c_ST_IDLE;
                release_d = 1'b1;
                lng_d     = 1'b0;
                cnt_d     = '0;
              end else begin
                cnt_d = cnt_q + c_ONE;
              end
            end else begin
              // release glitch: resume the hold without a new press
              state_d = lng_q ? c_ST_LONG : c_ST_HELD;
              cnt_d   = '0;
            end
          end
          default: begin
            state_d = c_ST_IDLE;
            cnt_d   = '0;
            lng_d   = 1'b0;
          end
        endcase
        level_d = (state_d == c_ST_HELD) || (state_d == c_ST_LONG) ||
                  (state_d == c_ST_DEB_R);
      end

      // Key state and registered outputs; reset aborts the key immediately
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q   <= c_ST_IDLE;
          cnt_q     <= '0;
          lng_q     <= 1'b0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          long_q    <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
          rep_q     <= 1'b0;
`endif
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          lng_q     <= lng_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
          long_q    <= long_d;
`ifdef KEY_AUTO_REPEAT_EN
          rep_q     <= rep_d;
`endif
        end
      end

      assign o_level[k]   = level_q;
      assign o_press[k]   = press_q;
      assign o_release[k] = release_q;
      assign o_long[k]    = long_q;
`ifdef KEY_AUTO_REPEAT_EN
      assign o_rep[k]     = rep_q;
`else
      assign o_rep[k]     = 1'b0;
`endif
    end
  endgenerate

endmodule

`default_nettype wire
